// File: rtl/binary_up_counter.sv
// WIDTH-bit binary up-counter with synchronous parallel load and async active-low clear.
// count comes straight from the state register, so it carries no combinational input path.
module binary_up_counter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] count
);

  // Priority is reset > load > increment; increment wraps modulo 2^WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= data_in;
    else
      count <= count + WIDTH'(1);
  end

endmodule

// File: tb/tb_binary_up_counter.sv
// Directed bench for binary_up_counter: async clear, free count/wrap, load, load-held, priority.
module tb_binary_up_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] data_in;
  logic [3:0] count;

  int total = 0;
  int bad   = 0;

  binary_up_counter #(.WIDTH(4)) dut (
    .data_in (data_in),
    .load    (load),
    .clk     (clk),
    .reset   (reset),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    data_in = 4'h0;
    #2 reset = 1'b0;
    #1 chk("reset_async_initial", count, 4'h0);

    // Held in reset, edges and load ignored
    load = 1'b1; data_in = 4'hA;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold", count, 4'h0);
    end

    // Free count after release: 1..15, then wrap to 0
    load = 1'b0;
    reset = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("free_count", count, 4'(i));
    end
    step(); chk("after_wrap", count, 4'h1);
    step(); chk("count_2", count, 4'h2);

    // Async reset mid-count, between edges
    #3 reset = 1'b0;
    #1 chk("async_mid_count", count, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold_count", count, 4'h0);
    end

    // Priority: reset beats load
    load = 1'b1; data_in = 4'h9;
    step(); chk("prio_reset_over_load", count, 4'h0);
    step(); chk("prio_reset_over_load2", count, 4'h0);
    reset = 1'b1;
    step(); chk("prio_release_load", count, 4'h9);

    // Load 13 then count 14,15,0,1,2
    data_in = 4'hD;
    step(); chk("load_13", count, 4'hD);
    load = 1'b0;
    data_in = 4'h3;
    step(); chk("cnt_14", count, 4'hE);
    step(); chk("cnt_15", count, 4'hF);
    step(); chk("cnt_wrap_0", count, 4'h0);
    step(); chk("cnt_1", count, 4'h1);
    step(); chk("cnt_2", count, 4'h2);

    // Load held high for 5 edges, then data change follows with one-cycle latency
    load = 1'b1; data_in = 4'hD;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("load_held_13", count, 4'hD);
    end
    data_in = 4'h5;
    #2 chk("load_no_comb_path", count, 4'hD);
    step(); chk("load_held_5", count, 4'h5);

    // Between-edge pulse on load is not sampled
    load = 1'b0;
    step(); chk("resume_6", count, 4'h6);
    #2 load = 1'b1; data_in = 4'hB;
    #2 load = 1'b0;
    step(); chk("glitch_ignored", count, 4'h7);

    // Boundary: load 15 then wrap
    load = 1'b1; data_in = 4'hF;
    step(); chk("load_15", count, 4'hF);
    load = 1'b0;
    step(); chk("load15_wrap0", count, 4'h0);
    step(); chk("load15_then1", count, 4'h1);

    // Reset asserted during a load cycle
    load = 1'b1; data_in = 4'hC;
    #2 reset = 1'b0;
    #1 chk("reset_during_load", count, 4'h0);
    step(); chk("reset_during_load_edge", count, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
